// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_pkg
//  Description : Shared types and constants for the multdiv sequencer:
//                FSM state encoding, operation select codes and the
//                default step counts of the iterative datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    // Radix-4 Booth needs 16 steps for 32 bits, non-restoring divide needs 32.
    localparam int DEF_MULT_CYCLES = 16;
    localparam int DEF_DIV_CYCLES  = 32;
    localparam int DEF_CNT_W       = 6;

endpackage
`default_nettype wire

// File: rtl/multdiv_step_counter.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_step_counter
//  Description : Step counter for the iterative datapath. Synchronous clear,
//                count enable, and an equality compare against the index of
//                the final step (so it never needs to wrap).
//  Revision    : 1.0 - initial release
// ============================================================================
module multdiv_step_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             last
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear has priority over counting.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last = (count_q == limit);

endmodule
`default_nettype wire

// File: rtl/multdiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_ctrl
//  Description : Sequencer for the shared iterative mult/div datapath.
//                Latches operands on a start pulse, strobes load once and
//                step N times, screens divide-by-zero, and returns the
//                registered result, exception flag and a ready pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] dp_opA,
    output logic [31:0] dp_opB,
    output logic        dp_op,
    output logic        dp_load,
    output logic        dp_step,
    input  logic [31:0] dp_result,
    input  logic        dp_overflow,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    localparam logic [CNT_W-1:0] c_mult_last = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_div_last  = CNT_W'(DIV_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic        op_q, op_d;
    logic        div0_q, div0_d;
    logic [31:0] result_q, result_d;
    logic        exc_q, exc_d;

    logic             w_start;
    logic             w_div0;
    logic             w_last;
    logic             w_cnt_en;
    logic [CNT_W-1:0] w_limit;

    // Multiply wins when both pulses arrive; a zero divisor never reaches the datapath.
    assign w_start  = ctrl_MULT | ctrl_DIV;
    assign w_div0   = !ctrl_MULT && ctrl_DIV && (data_operandB == 32'd0);
    assign w_limit  = (op_q == OP_DIV) ? c_div_last : c_mult_last;
    // Stop counting on the final step so the counter parks at N-1.
    assign w_cnt_en = (state_q == RUN) && !w_last;

    multdiv_step_counter #(
        .CNT_W (CNT_W)
    ) u_step_counter (
        .clk   (clock),
        .rst_n (reset),
        .clear (w_start),
        .en    (w_cnt_en),
        .limit (w_limit),
        .last  (w_last)
    );

    // Next state, operand latching and result capture; a start overrides everything.
    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        op_d     = op_q;
        div0_d   = div0_q;
        result_d = result_q;
        exc_d    = exc_q;

        case (state_q)
            IDLE: state_d = IDLE;
            LOAD: state_d = RUN;
            RUN: begin
                if (w_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (div0_q) begin
                    result_d = 32'd0;
                    exc_d    = 1'b1;
                end else begin
                    result_d = dp_result;
                    exc_d    = (op_q == OP_MULT) ? dp_overflow : 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new start silently aborts whatever is in flight, including a
        // pending result capture in DONE.
        if (w_start) begin
            state_d  = w_div0 ? DONE : LOAD;
            op_a_d   = data_operandA;
            op_b_d   = data_operandB;
            op_d     = ctrl_MULT ? OP_MULT : OP_DIV;
            div0_d   = w_div0;
            result_d = result_q;
            exc_d    = exc_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_a_q   <= 32'd0;
            op_b_q   <= 32'd0;
            op_q     <= OP_MULT;
            div0_q   <= 1'b0;
            result_q <= 32'd0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            op_q     <= op_d;
            div0_q   <= div0_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign dp_opA         = op_a_q;
    assign dp_opB         = op_b_q;
    assign dp_op          = op_q;
    assign dp_load        = (state_q == LOAD);
    assign dp_step        = (state_q == RUN);
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q != IDLE);
    assign data_result    = result_q;
    assign data_exception = exc_q;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multdiv_ctrl
//  Description : Self-checking bench for multdiv_ctrl. A behavioural datapath
//                answers the strobes; a transaction-level model predicts all
//                controller outputs every cycle; directed cases pin literal
//                latencies and results, then random traffic runs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = 32'd0;
    logic [31:0] data_operandB = 32'd0;
    logic [31:0] dp_opA, dp_opB;
    logic        dp_op, dp_load, dp_step;
    logic [31:0] dp_result;
    logic        dp_overflow;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    always #5 clock = ~clock;

    multdiv_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .dp_opA         (dp_opA),
        .dp_opB         (dp_opB),
        .dp_op          (dp_op),
        .dp_load        (dp_load),
        .dp_step        (dp_step),
        .dp_result      (dp_result),
        .dp_overflow    (dp_overflow),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int n_of(input logic op);
        return op ? 32 : 16;
    endfunction

    function automatic logic [31:0] ref_result(input logic op, input logic [31:0] a, input logic [31:0] b);
        longint pa, pb, r;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        if (!op)          r = pa * pb;
        else if (pb == 0) r = 0;
        else              r = pa / pb;
        return r[31:0];
    endfunction

    function automatic logic ref_ovf(input logic [31:0] a, input logic [31:0] b);
        longint p;
        logic [31:0] lo;
        p  = longint'($signed(a)) * longint'($signed(b));
        lo = p[31:0];
        return p != longint'($signed(lo));
    endfunction

    // Behavioural datapath: result is only correct after exactly N steps.
    int          dp_steps;
    logic [31:0] dpa, dpb;
    logic        dpop;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            dp_steps = 0; dpa = 0; dpb = 0; dpop = 0;
        end else if (dp_load) begin
            dpa = dp_opA; dpb = dp_opB; dpop = dp_op; dp_steps = 0;
        end else if (dp_step) begin
            dp_steps++;
        end
    end

    always_comb begin
        dp_result   = 32'hBAD0_0000 | 32'(dp_steps);
        dp_overflow = 1'b0;
        if (dp_steps == n_of(dpop)) begin
            dp_result   = ref_result(dpop, dpa, dpb);
            dp_overflow = !dpop && ref_ovf(dpa, dpb);
        end
    end

    // Transaction model: one pending op, tracked by its age in cycles since start.
    logic        m_pending, m_op, m_div0, m_exc;
    int          m_age;
    logic [31:0] m_a, m_b, m_result;
    always @(posedge clock or negedge reset) begin
        int da;
        if (!reset) begin
            m_pending = 0; m_op = 0; m_div0 = 0; m_exc = 0;
            m_age = 0; m_a = 0; m_b = 0; m_result = 0;
        end else if (ctrl_MULT || ctrl_DIV) begin
            m_op      = !ctrl_MULT;
            m_a       = data_operandA;
            m_b       = data_operandB;
            m_div0    = !ctrl_MULT && (data_operandB == 0);
            m_pending = 1;
            m_age     = 1;
        end else if (m_pending) begin
            da = m_div0 ? 1 : n_of(m_op) + 2;
            if (m_age == da) begin
                m_result  = m_div0 ? 32'd0 : ref_result(m_op, m_a, m_b);
                m_exc     = m_div0 ? 1'b1 : (!m_op && ref_ovf(m_a, m_b));
                m_pending = 0;
            end else begin
                m_age++;
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clock) begin
        int n, da;
        if (cmp_en) begin
            n  = n_of(m_op);
            da = m_div0 ? 1 : n + 2;
            chk1 ("busy",      busy,           m_pending);
            chk1 ("dp_load",   dp_load,        m_pending && !m_div0 && m_age == 1);
            chk1 ("dp_step",   dp_step,        m_pending && !m_div0 && m_age >= 2 && m_age <= n + 1);
            chk1 ("rdy",       data_resultRDY, m_pending && m_age == da);
            chk1 ("dp_op",     dp_op,          m_op);
            chk32("dp_opA",    dp_opA,         m_a);
            chk32("dp_opB",    dp_opB,         m_b);
            chk32("result",    data_result,    m_result);
            chk1 ("exception", data_exception, m_exc);
        end
    end

    task automatic run_op(input string nm, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] exp_res, input logic exp_exc,
                          input int exp_steps, input int exp_loads);
        int rdy_at, rdys, steps, loads;
        rdy_at = 0; rdys = 0; steps = 0; loads = 0;
        @(negedge clock);
        ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
        for (int n = 1; n <= exp_lat + 1; n++) begin
            @(negedge clock);
            if (n == 1) begin ctrl_MULT = 0; ctrl_DIV = 0; end
            if (dp_step) steps++;
            if (dp_load) loads++;
            if (data_resultRDY) begin
                rdys++;
                if (rdy_at == 0) rdy_at = n;
            end
        end
        chk32({nm, "_latency"}, rdy_at, exp_lat);
        chk32({nm, "_rdy_pulses"}, rdys, 1);
        chk32({nm, "_steps"}, steps, exp_steps);
        chk32({nm, "_loads"}, loads, exp_loads);
        chk32({nm, "_result"}, data_result, exp_res);
        chk1 ({nm, "_exception"}, data_exception, exp_exc);
    endtask

    task automatic abort_test();
        int rdy_at, rdys;
        rdy_at = 0; rdys = 0;
        @(negedge clock);
        ctrl_MULT = 1; data_operandA = 7; data_operandB = 8;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clock);
            if (n == 1) ctrl_MULT = 0;
            if (n == 5) begin ctrl_DIV = 1; data_operandA = 9; data_operandB = 3; end
            if (n == 6) ctrl_DIV = 0;
            if (data_resultRDY) begin
                rdys++;
                if (rdy_at == 0) rdy_at = n;
            end
            if (n == 3 || n == 20 || n == 39) chk32("abort_hold_result", data_result, 14);
            if (n == 40) chk32("abort_result", data_result, 3);
        end
        chk32("abort_latency", rdy_at, 39);
        chk32("abort_rdy_pulses", rdys, 1);
    endtask

    task automatic reset_test();
        @(negedge clock);
        ctrl_DIV = 1; data_operandA = 100; data_operandB = 7;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clock);
            if (n == 1) ctrl_DIV = 0;
        end
        chk1("pre_rst_busy", busy, 1'b1);
        #2 reset = 0;
        #1;
        chk1 ("rst_busy",   busy,           1'b0);
        chk1 ("rst_step",   dp_step,        1'b0);
        chk1 ("rst_load",   dp_load,        1'b0);
        chk1 ("rst_rdy",    data_resultRDY, 1'b0);
        chk1 ("rst_op",     dp_op,          1'b0);
        chk32("rst_opA",    dp_opA,         32'd0);
        chk32("rst_opB",    dp_opB,         32'd0);
        chk32("rst_result", data_result,    32'd0);
        chk1 ("rst_exc",    data_exception, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset = 1;
    endtask

    task automatic random_phase();
        int kind;
        logic [31:0] a, b;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clock);
            ctrl_MULT = 0; ctrl_DIV = 0;
            if ($urandom_range(0, 29) == 0) begin
                kind = $urandom_range(0, 3);
                a = $urandom;
                if ($urandom_range(0, 1) == 1) b = $urandom;
                else b = 32'($urandom_range(0, 300)) - 32'd150;
                if (b == 32'hFFFF_FFFF) b = 32'd1;
                if (kind == 2) b = 32'd0;
                data_operandA = a;
                data_operandB = b;
                ctrl_MULT = (kind == 0 || kind == 3);
                ctrl_DIV  = (kind != 0);
            end
        end
        @(negedge clock);
        ctrl_MULT = 0; ctrl_DIV = 0;
        repeat (40) @(negedge clock);
    endtask

    initial begin
        #1 reset = 0;
        #2 cmp_en = 1;
        repeat (2) @(negedge clock);
        chk1 ("reset_busy",   busy,        1'b0);
        chk32("reset_result", data_result, 32'd0);
        reset = 1;

        run_op("mult",     1, 0, 32'd124, 32'(-34), 18, 32'(-4216), 1'b0, 16, 1);
        run_op("mult_ovf", 1, 0, 32'h4000_0000, 32'd4, 18, 32'd0, 1'b1, 16, 1);
        run_op("div0",     0, 1, 32'd5, 32'd0, 1, 32'd0, 1'b1, 0, 0);
        run_op("div",      0, 1, 32'd100, 32'd7, 34, 32'd14, 1'b0, 32, 1);
        abort_test();
        reset_test();
        run_op("post_rst", 1, 0, 32'd3, 32'd3, 18, 32'd9, 1'b0, 16, 1);
        random_phase();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
